// File: rtl/mips_defs.sv
// Shared MIPS encoding definitions: opcode/funct constants (common with the
// arithmetic decoder), encoder mnemonic indices, instruction field positions
// and the encoder result type.
package mips_defs;

  // Primary opcodes
  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;

  // funct codes under OP_OTHER0
  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_XOR = 6'h26;
  localparam logic [5:0] OP0_NOR = 6'h27;

  // Encoder mnemonic indices; 10..15 are illegal
  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_NOR  = 4'd4,
    MN_XOR  = 4'd5,
    MN_ADDI = 4'd6,
    MN_ANDI = 4'd7,
    MN_ORI  = 4'd8,
    MN_XORI = 4'd9
  } mnem_e;

  // Field LSB positions within a 32-bit instruction word
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

endpackage

// File: rtl/mips_word_fifo.sv
// Count-based synchronous FIFO with valid/ready on both sides.
// Ports: clock, reset (async active-low), clear (sync flush),
//        push_valid/push_ready/push_data, pop_valid/pop_ready/pop_data.
// pop_data shows the head when non-empty, otherwise the last popped entry
// (zero after reset). No input-to-output pass-through.
module mips_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] last;
  logic             do_push, do_pop;

  assign push_ready = (count != CNT_W'(DEPTH));
  assign pop_valid  = (count != '0);
  assign do_push    = push_valid & push_ready & ~clear;
  assign do_pop     = pop_valid & pop_ready & ~clear;
  assign pop_data   = pop_valid ? mem[rd_ptr] : last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips_encode_stream.sv
// Symbolic ALU instruction -> 32-bit MIPS word emitter with sequential
// addressing and an output FIFO.
// Ports: clock, reset (async active-low), clear (sync flush);
//        in_valid/in_ready + in_mnem/in_rd/in_rs/in_rt/in_imm request;
//        out_valid/out_ready + out_instr/out_addr FIFO head;
//        except (one-cycle pulse after an illegal accept), err_count
//        (saturating illegal-request count).
module mips_encode_stream
  import mips_defs::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mnem,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        except,
  output logic [7:0]  err_count
);

  function automatic enc_t encode(input logic [3:0] mnem, input logic [4:0] rd,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [15:0] imm);
    enc_t       r;
    logic [5:0] opc;
    logic [5:0] funct;
    logic       is_r;
    opc     = OP_OTHER0;
    funct   = '0;
    is_r    = 1'b1;
    r.legal = 1'b1;
    case (mnem)
      MN_ADD:  funct = OP0_ADD;
      MN_SUB:  funct = OP0_SUB;
      MN_AND:  funct = OP0_AND;
      MN_OR:   funct = OP0_OR;
      MN_NOR:  funct = OP0_NOR;
      MN_XOR:  funct = OP0_XOR;
      MN_ADDI: begin opc = OP_ADDI; is_r = 1'b0; end
      MN_ANDI: begin opc = OP_ANDI; is_r = 1'b0; end
      MN_ORI:  begin opc = OP_ORI;  is_r = 1'b0; end
      MN_XORI: begin opc = OP_XORI; is_r = 1'b0; end
      default: begin r.legal = 1'b0; is_r = 1'b0; end
    endcase
    r.word = (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB);
    if (is_r) r.word = r.word | (32'(rd) << RD_LSB) | 32'(funct);
    else      r.word = r.word | 32'(imm);
    return r;
  endfunction

  enc_t        enc;
  logic        fifo_ready;
  logic        accept;
  logic        push;
  logic [31:0] pc;
  logic [63:0] head;

  assign enc      = encode(in_mnem, in_rd, in_rs, in_rt, in_imm);
  assign in_ready = fifo_ready & ~clear & reset;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc.legal;

  mips_word_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .push_valid (push),
    .push_ready (fifo_ready),
    .push_data  ({enc.word, pc}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  assign out_instr = head[63:32];
  assign out_addr  = head[31:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc        <= BASE_ADDR;
      except    <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      pc        <= BASE_ADDR;
      except    <= 1'b0;
      err_count <= '0;
    end else begin
      except <= accept & ~enc.legal;
      if (push) pc <= pc + 32'd4;
      if (accept && !enc.legal && err_count != '1) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mips_encode_stream.sv
module tb_mips_encode_stream;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_mnem = '0;
  logic [4:0]  in_rd = '0, in_rs = '0, in_rt = '0;
  logic [15:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        except;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc = BASE;
  int          model_err = 0;
  logic        exp_except = 1'b0;

  mips_encode_stream #(
    .DEPTH(4),
    .BASE_ADDR(32'h0040_0000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mnem   (in_mnem),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .except    (except),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_word(input logic [3:0] m, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
    logic [5:0] f;
    case (m)
      4'd0:    f = 6'h20;
      4'd1:    f = 6'h22;
      4'd2:    f = 6'h24;
      4'd3:    f = 6'h25;
      4'd4:    f = 6'h27;
      default: f = 6'h26;
    endcase
    if (m < 4'd6) return {6'h00, rs, rt, rd, 5'b00000, f};
    case (m)
      4'd6:    return {6'h08, rs, rt, imm};
      4'd7:    return {6'h0C, rs, rt, imm};
      4'd8:    return {6'h0D, rs, rt, imm};
      default: return {6'h0E, rs, rt, imm};
    endcase
  endfunction

  // Scoreboard: push on observed accept, pop/compare on observed pop.
  always @(negedge clock) begin
    logic [63:0] e;
    if (!reset) begin
      exp_q.delete();
      model_pc   = BASE;
      model_err  = 0;
      exp_except = 1'b0;
    end else begin
      checks++;
      if (except !== exp_except) begin
        errors++;
        $display("FAIL except_pulse: got %b expected %b at %0t", except, exp_except, $time);
      end
      checks++;
      if (err_count !== 8'(model_err)) begin
        errors++;
        $display("FAIL err_count_track: got %0d expected %0d at %0t", err_count, model_err, $time);
      end
      if (clear) begin
        exp_q.delete();
        model_pc   = BASE;
        model_err  = 0;
        exp_except = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h @%h expected no word at %0t", out_instr, out_addr, $time);
          end else begin
            e = exp_q.pop_front();
            if ({out_instr, out_addr} !== e) begin
              errors++;
              $display("FAIL sb_word: got %h @%h expected %h @%h at %0t",
                       out_instr, out_addr, e[63:32], e[31:0], $time);
            end
          end
        end
        exp_except = 1'b0;
        if (in_valid && in_ready) begin
          if (in_mnem < 4'd10) begin
            exp_q.push_back({ref_word(in_mnem, in_rd, in_rs, in_rt, in_imm), model_pc});
            model_pc = model_pc + 32'd4;
          end else begin
            exp_except = 1'b1;
            if (model_err < 255) model_err++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [15:0] imm);
    bit done = 0;
    in_valid = 1'b1;
    in_mnem  = m;
    in_rd    = rd;
    in_rs    = rs;
    in_rt    = rt;
    in_imm   = imm;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clock);
      if (in_ready) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (!out_valid && exp_q.size() == 0) done = 1;
      else step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: out_valid=%b pending=%0d expected empty", out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    #3;
    checks++;
    if ({out_valid, except, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got v/x/r=%b expected 000", {out_valid, except, in_ready});
    end
    checks++;
    if ({out_instr, out_addr, err_count} !== 72'h0) begin
      errors++;
      $display("FAIL reset_values: got %h %h %0d expected zeros", out_instr, out_addr, err_count);
    end
    step();
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    do_clear();
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_pre_valid: got %b expected 0", out_valid);
    end
    send(4'd0, 5'd3, 5'd1, 5'd2, 16'h0);
    checks++;
    if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h0022_1820, BASE}) begin
      errors++;
      $display("FAIL add_word: got v=%b %h @%h expected 1 00221820 @%h", out_valid, out_instr, out_addr, BASE);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_one_cycle: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_itype();
    do_clear();
    out_ready = 1'b1;
    send(4'd6, 5'd9, 5'd4, 5'd5, 16'hFFFF);
    checks++;
    if ({out_instr, out_addr} !== {32'h2085_FFFF, BASE}) begin
      errors++;
      $display("FAIL addi_word: got %h @%h expected 2085ffff @%h", out_instr, out_addr, BASE);
    end
    send(4'd9, 5'd0, 5'd6, 5'd7, 16'h00F0);
    checks++;
    if ({out_instr, out_addr} !== {32'h38C7_00F0, BASE + 32'd4}) begin
      errors++;
      $display("FAIL xori_word: got %h @%h expected 38c700f0 @%h", out_instr, out_addr, BASE + 32'd4);
    end
    step();
  endtask

  task automatic test_nor_garbage_rd();
    do_clear();
    out_ready = 1'b1;
    send(4'd4, 5'd0, 5'd31, 5'd31, 16'hABCD);
    checks++;
    if (out_instr !== 32'h03FF_0027) begin
      errors++;
      $display("FAIL nor_word: got %h expected 03ff0027", out_instr);
    end
    send(4'd8, 5'h1F, 5'd2, 5'd3, 16'h1234);
    checks++;
    if ({out_instr, out_addr} !== {32'h3443_1234, BASE + 32'd4}) begin
      errors++;
      $display("FAIL ori_rd_ignored: got %h @%h expected 34431234 @%h", out_instr, out_addr, BASE + 32'd4);
    end
    step();
  endtask

  task automatic test_illegal();
    do_clear();
    out_ready = 1'b1;
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'h5555);
    checks++;
    if ({except, out_valid, err_count} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL illegal_flag: got except=%b valid=%b err=%0d expected 1 0 1", except, out_valid, err_count);
    end
    step();
    checks++;
    if (except !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse_len: got %b expected 0", except);
    end
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    checks++;
    if (out_addr !== BASE) begin
      errors++;
      $display("FAIL illegal_pc_hold: got %h expected %h", out_addr, BASE);
    end
    step();
    in_valid = 1'b1;
    in_mnem  = 4'd15;
    repeat (300) step();
    in_valid = 1'b0;
    step();
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: got %0d expected 255", err_count);
    end
  endtask

  task automatic test_full_backpressure();
    logic exp_r;
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_mnem  = 4'd0;
      in_rd    = 5'(i + 1);
      in_rs    = 5'(i);
      in_rt    = 5'd0;
      @(negedge clock);
      exp_r = (i < 4);
      checks++;
      if (in_ready !== exp_r) begin
        errors++;
        $display("FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, exp_r);
      end
      if (i < 4) step();
    end
    step();
    out_ready = 1'b1;
    checks++;
    if (out_addr !== BASE) begin
      errors++;
      $display("FAIL full_head: got %h expected %h", out_addr, BASE);
    end
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_same_cycle: in_ready got %b expected 0", in_ready);
    end
    step();
    checks++;
    if (out_addr !== BASE + 32'd4) begin
      errors++;
      $display("FAIL full_second: got %h expected %h", out_addr, BASE + 32'd4);
    end
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: in_ready got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    drain();
    checks++;
    if (out_addr !== BASE + 32'd16) begin
      errors++;
      $display("FAIL full_fifth_addr: got %h expected %h", out_addr, BASE + 32'd16);
    end
  endtask

  task automatic test_clear();
    do_clear();
    out_ready = 1'b0;
    send(4'd2, 5'd1, 5'd1, 5'd1, 16'h0);
    send(4'd3, 5'd2, 5'd2, 5'd2, 16'h0);
    send(4'd5, 5'd3, 5'd3, 5'd3, 16'h0);
    in_valid = 1'b1;
    in_mnem  = 4'd0;
    clear    = 1'b1;
    @(negedge clock);
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      errors++;
      $display("FAIL clear_ready: got ready/valid=%b expected 01", {in_ready, out_valid});
    end
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush: out_valid got %b expected 0", out_valid);
    end
    out_ready = 1'b1;
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0);
    checks++;
    if ({out_instr, out_addr} !== {32'h00A6_2022, BASE}) begin
      errors++;
      $display("FAIL clear_restart: got %h @%h expected 00a62022 @%h", out_instr, out_addr, BASE);
    end
    drain();
  endtask

  task automatic test_async_reset();
    do_clear();
    out_ready = 1'b0;
    send(4'd13, 5'd0, 5'd0, 5'd0, 16'h0);
    send(4'd7, 5'd0, 5'd1, 5'd2, 16'h00FF);
    send(4'd0, 5'd3, 5'd4, 5'd5, 16'h0);
    send(4'd1, 5'd6, 5'd7, 5'd8, 16'h0);
    out_ready = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, except, err_count} !== 11'h0) begin
      errors++;
      $display("FAIL async_flags: got v=%b r=%b x=%b err=%0d expected zeros",
               out_valid, in_ready, except, err_count);
    end
    checks++;
    if ({out_instr, out_addr} !== 64'h0) begin
      errors++;
      $display("FAIL async_values: got %h @%h expected 0 @0", out_instr, out_addr);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_lost: out_valid got %b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_itype();
    test_nor_garbage_rd();
    test_illegal();
    test_full_backpressure();
    test_clear();
    test_async_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
